if_id_stage_ctrl: RTL

Front-end pipeline controller that acts on the stall and flush requests raised by hazard detection and branch resolution. It owns the program counter and the IF/ID pipeline register, and drives the bubble-select signal for the ID/EX control mux. It sits between instruction memory and the ID stage.

---
 rtl/if_id_stage_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/if_id_stage_ctrl.sv
// Front-end controller: owns the PC and IF/ID register, applies stall/flush/fetch-wait actions.
// Define STALL_PERF_CNT_EN to add the Perf_stall_cnt / Perf_flush_cnt counters and ports.
module if_id_stage_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned STALL_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall_req,
  input  logic        Flush_req,
  input  logic [31:0] Branch_target,
  input  logic [31:0] IMem_instr,
  input  logic        IMem_ready,
  output logic [31:0] PC,
  output logic [31:0] IF_ID_Instr,
  output logic [31:0] IF_ID_PCPlus4,
  output logic        IF_ID_Valid,
  output logic        ID_EX_Bubble,
  output logic        Stall_err
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [31:0] Perf_stall_cnt,
  output logic [31:0] Perf_flush_cnt
`endif
);

  localparam logic [7:0] LP_STALL_LIMIT = 8'(STALL_LIMIT);
  localparam logic [31:0] LP_NOP        = 32'h0000_0000;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StHold  = 2'd1,
    StIwait = 2'd2
  } state_e;

  typedef enum logic [3:0] {
    ActStall   = 4'b0001,
    ActFlush   = 4'b0010,
    ActWait    = 4'b0100,
    ActAdvance = 4'b1000
  } action_e;

  state_e      r_state;
  state_e      w_state_nxt;
  action_e     w_act;

  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_pc4;
  logic        r_valid;
  logic [7:0]  r_hold_cnt;
  logic        r_stall_err;

  logic [31:0] w_pc_nxt;
  logic [31:0] w_instr_nxt;
  logic [31:0] w_pc4_nxt;
  logic        w_valid_nxt;
  logic [7:0]  w_hold_cnt_nxt;
  logic        w_stall_err_nxt;
  logic [31:0] w_pc_plus4;

`ifdef STALL_PERF_CNT_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_flush;
  logic [31:0] w_perf_stall_nxt;
  logic [31:0] w_perf_flush_nxt;
`endif

  assign w_pc_plus4 = r_pc + 32'd4;

  // Fixed priority: stall beats flush so the branch in ID is re-resolved after the hold.
  always_comb begin
    if (Stall_req) begin
      w_act = ActStall;
    end else if (Flush_req) begin
      w_act = ActFlush;
    end else if (!IMem_ready) begin
      w_act = ActWait;
    end else begin
      w_act = ActAdvance;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_instr_nxt     = r_instr;
    w_pc4_nxt       = r_pc4;
    w_valid_nxt     = r_valid;
    w_hold_cnt_nxt  = 8'd0;
    w_stall_err_nxt = r_stall_err;
`ifdef STALL_PERF_CNT_EN
    w_perf_stall_nxt = r_perf_stall;
    w_perf_flush_nxt = r_perf_flush;
`endif
    unique case (w_act)
      ActStall: begin
        w_state_nxt    = StHold;
        w_hold_cnt_nxt = (r_hold_cnt == 8'hFF) ? r_hold_cnt : r_hold_cnt + 8'd1;
        if (w_hold_cnt_nxt >= LP_STALL_LIMIT) begin
          w_stall_err_nxt = 1'b1;
        end
`ifdef STALL_PERF_CNT_EN
        w_perf_stall_nxt = r_perf_stall + 32'd1;
`endif
      end
      ActFlush: begin
        w_state_nxt = StRun;
        w_pc_nxt    = Branch_target;
        w_instr_nxt = LP_NOP;
        w_valid_nxt = 1'b0;
`ifdef STALL_PERF_CNT_EN
        w_perf_flush_nxt = r_perf_flush + 32'd1;
`endif
      end
      ActWait: begin
        w_state_nxt = StIwait;
        w_instr_nxt = LP_NOP;
        w_valid_nxt = 1'b0;
      end
      ActAdvance: begin
        w_state_nxt = StRun;
        w_pc_nxt    = w_pc_plus4;
        w_instr_nxt = IMem_instr;
        w_pc4_nxt   = w_pc_plus4;
        w_valid_nxt = 1'b1;
      end
      default: begin
        w_state_nxt = r_state;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StRun;
      r_pc        <= RESET_PC;
      r_instr     <= LP_NOP;
      r_pc4       <= 32'd0;
      r_valid     <= 1'b0;
      r_hold_cnt  <= 8'd0;
      r_stall_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_instr     <= w_instr_nxt;
      r_pc4       <= w_pc4_nxt;
      r_valid     <= w_valid_nxt;
      r_hold_cnt  <= w_hold_cnt_nxt;
      r_stall_err <= w_stall_err_nxt;
    end
  end

`ifdef STALL_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_stall <= 32'd0;
      r_perf_flush <= 32'd0;
    end else begin
      r_perf_stall <= w_perf_stall_nxt;
      r_perf_flush <= w_perf_flush_nxt;
    end
  end

  assign Perf_stall_cnt = r_perf_stall;
  assign Perf_flush_cnt = r_perf_flush;
`endif

  assign PC            = r_pc;
  assign IF_ID_Instr   = r_instr;
  assign IF_ID_PCPlus4 = r_pc4;
  assign IF_ID_Valid   = r_valid;
  assign Stall_err     = r_stall_err;
  assign ID_EX_Bubble  = Stall_req | ~r_valid;

endmodule
